// File: rtl/rtc_calendar_if.sv
// Time/date load and readout bundle for rtc_calendar.
// The alarm signals exist only when RTC_ALARM_EN is defined.
interface rtc_calendar_if #(
   parameter int YEAR_W = 7
);
   logic              synced;
   logic [4:0]        hour_in;
   logic [5:0]        min_in;
   logic [5:0]        sec_in;
   logic [4:0]        day_in;
   logic [3:0]        month_in;
   logic [YEAR_W-1:0] year_in;

   logic [4:0]        hour;
   logic [5:0]        min;
   logic [5:0]        sec;
   logic [4:0]        day;
   logic [3:0]        month;
   logic [YEAR_W-1:0] year;
   logic              tick;

`ifdef RTC_ALARM_EN
   logic              alarm_set;
   logic [4:0]        alarm_hour_in;
   logic [5:0]        alarm_min_in;
   logic              alarm_ack;
   logic              alarm_irq;

   modport master (
      output synced, hour_in, min_in, sec_in, day_in, month_in, year_in,
      output alarm_set, alarm_hour_in, alarm_min_in, alarm_ack,
      input  hour, min, sec, day, month, year, tick, alarm_irq
   );

   modport slave (
      input  synced, hour_in, min_in, sec_in, day_in, month_in, year_in,
      input  alarm_set, alarm_hour_in, alarm_min_in, alarm_ack,
      output hour, min, sec, day, month, year, tick, alarm_irq
   );
`else
   modport master (
      output synced, hour_in, min_in, sec_in, day_in, month_in, year_in,
      input  hour, min, sec, day, month, year, tick
   );

   modport slave (
      input  synced, hour_in, min_in, sec_in, day_in, month_in, year_in,
      output hour, min, sec, day, month, year, tick
   );
`endif
endinterface

// File: rtl/rtc_calendar.sv
// Real-time clock/calendar: per-second prescaler, carry chain sec..year, sanitised loads.
// Optional alarm compare/interrupt compiled in with macro RTC_ALARM_EN.
module rtc_calendar #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int YEAR_W   = 7
) (
   input  logic          clk,
   input  logic          rst,
   rtc_calendar_if.slave bus
);

   localparam int              PRE_W   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_FREQ - 1);

   // Days in month m of year y; year 100 (2100) is not a leap year.
   function automatic logic [4:0] month_len(input logic [3:0] m, input logic [YEAR_W-1:0] y);
      logic [31:0] y_ext;
      logic        leap;
      y_ext = 32'(y);
      leap  = (y_ext[1:0] == 2'b00) && (y_ext != 32'd100);
      case (m)
         4'd2:                    month_len = leap ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11: month_len = 5'd30;
         default:                 month_len = 5'd31;
      endcase
   endfunction

   function automatic logic [4:0] sane_hour(input logic [4:0] h);
      sane_hour = (h > 5'd23) ? 5'd0 : h;
   endfunction

   function automatic logic [5:0] sane_min(input logic [5:0] m);
      sane_min = (m > 6'd59) ? 6'd0 : m;
   endfunction

   logic [PRE_W-1:0]  presc_r;
   logic              tick_r;
   logic [4:0]        hour_r;
   logic [5:0]        min_r;
   logic [5:0]        sec_r;
   logic [4:0]        day_r;
   logic [3:0]        month_r;
   logic [YEAR_W-1:0] year_r;

   logic              wrap_s;
   logic [4:0]        hour_inc_s;
   logic [5:0]        min_inc_s;
   logic [5:0]        sec_inc_s;
   logic [4:0]        day_inc_s;
   logic [3:0]        month_inc_s;
   logic [YEAR_W-1:0] year_inc_s;

   logic [4:0]        ld_hour_s;
   logic [5:0]        ld_min_s;
   logic [5:0]        ld_sec_s;
   logic [3:0]        ld_month_s;
   logic [4:0]        ld_day_s;

   assign wrap_s = (presc_r == PRE_MAX);

   // Day is validated against the already-sanitised month and the incoming year.
   assign ld_hour_s  = sane_hour(bus.hour_in);
   assign ld_min_s   = sane_min(bus.min_in);
   assign ld_sec_s   = sane_min(bus.sec_in);
   assign ld_month_s = ((bus.month_in == 4'd0) || (bus.month_in > 4'd12)) ? 4'd1 : bus.month_in;
   assign ld_day_s   = ((bus.day_in == 5'd0) || (bus.day_in > month_len(ld_month_s, bus.year_in)))
                       ? 5'd1 : bus.day_in;

   // Time/date one second ahead of the current registers (carry chain).
   always_comb begin
      hour_inc_s  = hour_r;
      min_inc_s   = min_r;
      sec_inc_s   = sec_r;
      day_inc_s   = day_r;
      month_inc_s = month_r;
      year_inc_s  = year_r;
      if (sec_r >= 6'd59) begin
         sec_inc_s = 6'd0;
         if (min_r >= 6'd59) begin
            min_inc_s = 6'd0;
            if (hour_r >= 5'd23) begin
               hour_inc_s = 5'd0;
               if (day_r >= month_len(month_r, year_r)) begin
                  day_inc_s = 5'd1;
                  if (month_r >= 4'd12) begin
                     month_inc_s = 4'd1;
                     year_inc_s  = year_r + YEAR_W'(1);
                  end else begin
                     month_inc_s = month_r + 4'd1;
                  end
               end else begin
                  day_inc_s = day_r + 5'd1;
               end
            end else begin
               hour_inc_s = hour_r + 5'd1;
            end
         end else begin
            min_inc_s = min_r + 6'd1;
         end
      end else begin
         sec_inc_s = sec_r + 6'd1;
      end
   end

   // Prescaler, tick and calendar registers; a load wins over a coincident wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_r <= {PRE_W{1'b0}};
         tick_r  <= 1'b0;
         hour_r  <= 5'd0;
         min_r   <= 6'd0;
         sec_r   <= 6'd0;
         day_r   <= 5'd1;
         month_r <= 4'd1;
         year_r  <= {YEAR_W{1'b0}};
      end else if (bus.synced) begin
         presc_r <= {PRE_W{1'b0}};
         tick_r  <= 1'b0;
         hour_r  <= ld_hour_s;
         min_r   <= ld_min_s;
         sec_r   <= ld_sec_s;
         day_r   <= ld_day_s;
         month_r <= ld_month_s;
         year_r  <= bus.year_in;
      end else if (wrap_s) begin
         presc_r <= {PRE_W{1'b0}};
         tick_r  <= 1'b1;
         hour_r  <= hour_inc_s;
         min_r   <= min_inc_s;
         sec_r   <= sec_inc_s;
         day_r   <= day_inc_s;
         month_r <= month_inc_s;
         year_r  <= year_inc_s;
      end else begin
         presc_r <= presc_r + PRE_W'(1);
         tick_r  <= 1'b0;
      end
   end

   assign bus.hour  = hour_r;
   assign bus.min   = min_r;
   assign bus.sec   = sec_r;
   assign bus.day   = day_r;
   assign bus.month = month_r;
   assign bus.year  = year_r;
   assign bus.tick  = tick_r;

`ifdef RTC_ALARM_EN
   logic [4:0] alarm_hour_r;
   logic [5:0] alarm_min_r;
   logic       alarm_irq_r;
   logic       match_s;

   // Only a counted second landing on hh:mm:00 matches; loads never do.
   assign match_s = !bus.synced && wrap_s && (sec_inc_s == 6'd0) &&
                    (min_inc_s == alarm_min_r) && (hour_inc_s == alarm_hour_r);

   // Stored alarm time and sticky interrupt; a fresh match beats a same-cycle ack.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alarm_hour_r <= 5'd0;
         alarm_min_r  <= 6'd0;
         alarm_irq_r  <= 1'b0;
      end else begin
         if (bus.alarm_set) begin
            alarm_hour_r <= sane_hour(bus.alarm_hour_in);
            alarm_min_r  <= sane_min(bus.alarm_min_in);
         end else begin
            alarm_hour_r <= alarm_hour_r;
            alarm_min_r  <= alarm_min_r;
         end
         if (match_s) begin
            alarm_irq_r <= 1'b1;
         end else if (bus.alarm_ack) begin
            alarm_irq_r <= 1'b0;
         end else begin
            alarm_irq_r <= alarm_irq_r;
         end
      end
   end

   assign bus.alarm_irq = alarm_irq_r;
`endif

endmodule

// File: tb/tb_rtc_calendar.sv
// Directed self-checking bench for rtc_calendar (CLK_FREQ=10, YEAR_W=7).
// Alarm scenarios are exercised when RTC_ALARM_EN is defined.
module tb_rtc_calendar;
   localparam int CLK_FREQ = 10;
   localparam int YEAR_W   = 7;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;

   rtc_calendar_if #(.YEAR_W(YEAR_W)) bus ();

   rtc_calendar #(.CLK_FREQ(CLK_FREQ), .YEAR_W(YEAR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [32:0] now_s;
   assign now_s = {bus.hour, bus.min, bus.sec, bus.day, bus.month, bus.year};

   function automatic logic [32:0] pack(input int h, input int m, input int s,
                                        input int d, input int mo, input int y);
      return {5'(h), 6'(m), 6'(s), 5'(d), 4'(mo), 7'(y)};
   endfunction

   task automatic load(input int h, input int m, input int s,
                       input int d, input int mo, input int y);
      @(negedge clk);
      bus.hour_in  = 5'(h);
      bus.min_in   = 6'(m);
      bus.sec_in   = 6'(s);
      bus.day_in   = 5'(d);
      bus.month_in = 4'(mo);
      bus.year_in  = 7'(y);
      bus.synced   = 1'b1;
      @(negedge clk);
      bus.synced   = 1'b0;
   endtask

   task automatic test_reset();
      rst        = 1'b0;
      bus.synced = 1'b0;
      load_zero();
      repeat (3) @(negedge clk);
      n_checks++;
      if (now_s !== pack(0, 0, 0, 1, 1, 0) || bus.tick !== 1'b0)
         $display("FAIL reset_state: got %h tick %b want %h tick 0", now_s, bus.tick, pack(0, 0, 0, 1, 1, 0));
      else n_pass++;
      rst = 1'b1;
   endtask

   task automatic load_zero();
      bus.hour_in  = 5'd0;
      bus.min_in   = 6'd0;
      bus.sec_in   = 6'd0;
      bus.day_in   = 5'd1;
      bus.month_in = 4'd1;
      bus.year_in  = 7'd0;
`ifdef RTC_ALARM_EN
      bus.alarm_set     = 1'b0;
      bus.alarm_hour_in = 5'd0;
      bus.alarm_min_in  = 6'd0;
      bus.alarm_ack     = 1'b0;
`endif
   endtask

   task automatic test_count();
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         n_checks++;
         if (bus.tick !== ((k % 10) == 0))
            $display("FAIL count_tick: cycle %0d got %b want %b", k, bus.tick, ((k % 10) == 0));
         else n_pass++;
         n_checks++;
         if (now_s !== pack(0, 0, k / 10, 1, 1, 0))
            $display("FAIL count_time: cycle %0d got %h want %h", k, now_s, pack(0, 0, k / 10, 1, 1, 0));
         else n_pass++;
      end
   endtask

   task automatic test_rollover();
      load(23, 59, 58, 31, 12, 5);
      n_checks++;
      if (now_s !== pack(23, 59, 58, 31, 12, 5))
         $display("FAIL rollover_load: got %h want %h", now_s, pack(23, 59, 58, 31, 12, 5));
      else n_pass++;
      repeat (10) @(negedge clk);
      n_checks++;
      if (now_s !== pack(23, 59, 59, 31, 12, 5) || bus.tick !== 1'b1)
         $display("FAIL rollover_59: got %h tick %b want %h tick 1", now_s, bus.tick, pack(23, 59, 59, 31, 12, 5));
      else n_pass++;
      repeat (10) @(negedge clk);
      n_checks++;
      if (now_s !== pack(0, 0, 0, 1, 1, 6))
         $display("FAIL rollover_year: got %h want %h", now_s, pack(0, 0, 0, 1, 1, 6));
      else n_pass++;
   endtask

   task automatic test_leap();
      load(23, 59, 59, 28, 2, 4);
      repeat (10) @(negedge clk);
      n_checks++;
      if (now_s !== pack(0, 0, 0, 29, 2, 4))
         $display("FAIL leap_y4: got %h want %h", now_s, pack(0, 0, 0, 29, 2, 4));
      else n_pass++;
      load(23, 59, 59, 28, 2, 100);
      repeat (10) @(negedge clk);
      n_checks++;
      if (now_s !== pack(0, 0, 0, 1, 3, 100))
         $display("FAIL leap_y100: got %h want %h", now_s, pack(0, 0, 0, 1, 3, 100));
      else n_pass++;
   endtask

   task automatic test_sync_priority();
      load(10, 20, 30, 15, 6, 7);
      repeat (9) @(negedge clk);
      bus.sec_in = 6'd40;
      bus.synced = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++;
         if (now_s !== pack(10, 20, 40, 15, 6, 7) || bus.tick !== 1'b0)
            $display("FAIL sync_hold: cycle %0d got %h tick %b want %h tick 0", k, now_s, bus.tick, pack(10, 20, 40, 15, 6, 7));
         else n_pass++;
      end
      bus.synced = 1'b0;
      repeat (9) @(negedge clk);
      n_checks++;
      if (now_s !== pack(10, 20, 40, 15, 6, 7) || bus.tick !== 1'b0)
         $display("FAIL sync_restart_early: got %h tick %b want %h tick 0", now_s, bus.tick, pack(10, 20, 40, 15, 6, 7));
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (now_s !== pack(10, 20, 41, 15, 6, 7) || bus.tick !== 1'b1)
         $display("FAIL sync_restart_tick: got %h tick %b want %h tick 1", now_s, bus.tick, pack(10, 20, 41, 15, 6, 7));
      else n_pass++;
   endtask

   task automatic test_sanitise();
      load(25, 10, 61, 31, 4, 3);
      n_checks++;
      if (now_s !== pack(0, 10, 0, 1, 4, 3))
         $display("FAIL sanitise_a: got %h want %h", now_s, pack(0, 10, 0, 1, 4, 3));
      else n_pass++;
      load(5, 60, 10, 30, 13, 3);
      n_checks++;
      if (now_s !== pack(5, 0, 10, 30, 1, 3))
         $display("FAIL sanitise_month13: got %h want %h", now_s, pack(5, 0, 10, 30, 1, 3));
      else n_pass++;
      load(1, 2, 3, 29, 2, 100);
      n_checks++;
      if (now_s !== pack(1, 2, 3, 1, 2, 100))
         $display("FAIL sanitise_feb100: got %h want %h", now_s, pack(1, 2, 3, 1, 2, 100));
      else n_pass++;
      load(1, 2, 3, 0, 0, 8);
      n_checks++;
      if (now_s !== pack(1, 2, 3, 1, 1, 8))
         $display("FAIL sanitise_zero: got %h want %h", now_s, pack(1, 2, 3, 1, 1, 8));
      else n_pass++;
      load(1, 2, 3, 29, 2, 8);
      n_checks++;
      if (now_s !== pack(1, 2, 3, 29, 2, 8))
         $display("FAIL sanitise_feb29_ok: got %h want %h", now_s, pack(1, 2, 3, 29, 2, 8));
      else n_pass++;
   endtask

`ifdef RTC_ALARM_EN
   task automatic set_alarm(input int h, input int m);
      @(negedge clk);
      bus.alarm_hour_in = 5'(h);
      bus.alarm_min_in  = 6'(m);
      bus.alarm_set     = 1'b1;
      @(negedge clk);
      bus.alarm_set     = 1'b0;
   endtask

   task automatic test_alarm();
      set_alarm(7, 30);
      load(7, 29, 59, 1, 1, 0);
      repeat (9) @(negedge clk);
      n_checks++;
      if (bus.alarm_irq !== 1'b0) $display("FAIL alarm_early: got %b want 0", bus.alarm_irq);
      else n_pass++;
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.alarm_irq !== 1'b1) $display("FAIL alarm_fire: got %b want 1", bus.alarm_irq);
      else n_pass++;
      repeat (5) @(negedge clk);
      n_checks++;
      if (bus.alarm_irq !== 1'b1) $display("FAIL alarm_hold: got %b want 1", bus.alarm_irq);
      else n_pass++;
      bus.alarm_ack = 1'b1;
      @(negedge clk);
      bus.alarm_ack = 1'b0;
      n_checks++;
      if (bus.alarm_irq !== 1'b0) $display("FAIL alarm_ack: got %b want 0", bus.alarm_irq);
      else n_pass++;
      load(7, 30, 0, 1, 1, 0);
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.alarm_irq !== 1'b0) $display("FAIL alarm_load_match: got %b want 0", bus.alarm_irq);
      else n_pass++;
      load(7, 29, 59, 1, 1, 0);
      repeat (9) @(negedge clk);
      bus.alarm_ack = 1'b1;
      @(negedge clk);
      bus.alarm_ack = 1'b0;
      n_checks++;
      if (bus.alarm_irq !== 1'b1) $display("FAIL alarm_ack_vs_match: got %b want 1", bus.alarm_irq);
      else n_pass++;
      bus.alarm_ack = 1'b1;
      @(negedge clk);
      bus.alarm_ack = 1'b0;
      set_alarm(30, 70);
      load(23, 59, 59, 1, 1, 0);
      repeat (11) @(negedge clk);
      n_checks++;
      if (bus.alarm_irq !== 1'b1) $display("FAIL alarm_sanitised: got %b want 1", bus.alarm_irq);
      else n_pass++;
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if (bus.alarm_irq !== 1'b0) $display("FAIL alarm_reset: got %b want 0", bus.alarm_irq);
      else n_pass++;
      @(negedge clk);
      rst = 1'b1;
   endtask
`endif

   task automatic test_async_reset();
      load(12, 34, 56, 20, 7, 9);
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if (now_s !== pack(0, 0, 0, 1, 1, 0) || bus.tick !== 1'b0)
         $display("FAIL async_reset: got %h tick %b want %h tick 0", now_s, bus.tick, pack(0, 0, 0, 1, 1, 0));
      else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      repeat (9) @(negedge clk);
      n_checks++;
      if (bus.tick !== 1'b0 || now_s !== pack(0, 0, 0, 1, 1, 0))
         $display("FAIL resume_early: got %h tick %b want %h tick 0", now_s, bus.tick, pack(0, 0, 0, 1, 1, 0));
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (bus.tick !== 1'b1 || now_s !== pack(0, 0, 1, 1, 1, 0))
         $display("FAIL resume_tick: got %h tick %b want %h tick 1", now_s, bus.tick, pack(0, 0, 1, 1, 1, 0));
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_count();
      test_rollover();
      test_leap();
      test_sync_priority();
      test_sanitise();
`ifdef RTC_ALARM_EN
      test_alarm();
`endif
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/rtc_calendar.md
RTC_CALENDAR -- requirements
Module: rtc_calendar

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000: clk cycles per second, minimum 2.
REQ-002 SHALL have parameter YEAR_W, default 7: year width; year 0 is 2000.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port synced  input  1  one-cycle load strobe for all *_in fields.
REQ-006 SHALL have ports hour_in 5, min_in 6, sec_in 6, day_in 5, month_in 4, year_in YEAR_W; all inputs; values to load.
REQ-007 SHALL have ports hour 5, min 6, sec 6, day 5, month 4, year YEAR_W; all outputs; registered current time and date.
REQ-008 SHALL have port tick  output  1  one-cycle pulse per elapsed second.
REQ-009 SHALL have ports alarm_set input 1, alarm_hour_in input 5, alarm_min_in input 6, alarm_ack input 1, alarm_irq output 1 (present only per REQ-028).

Function
REQ-010 SHALL count a prescaler 0..CLK_FREQ-1 and wrap it to 0; tick SHALL be high, registered, in the cycle after the prescaler held CLK_FREQ-1.
REQ-011 SHALL advance sec on the same edge that asserts tick; new time visible together with tick.
REQ-012 SHALL wrap sec 59->0 and carry into min; min 59->0 carry hour; hour 23->0 carry day.
REQ-013 SHALL wrap day from month length to 1 and carry month; month 12->1 carry year; year all-ones->0.
REQ-014 SHALL use month lengths 31,28/29,31,30,31,30,31,31,30,31,30,31; February 29 when year%4==0 and year!=100.
REQ-015 SHALL load every *_in field on the edge where synced is high; prescaler cleared to 0; tick low next cycle.
REQ-016 SHALL give synced priority over a coincident tick; that second is not counted.
REQ-017 SHALL sanitise loads: sec_in/min_in >59 -> 0; hour_in >23 -> 0; month_in 0 or >12 -> 1; day_in 0 or above the length of the loaded month/year -> 1.
REQ-018 SHALL hold synced asserted for multiple cycles as repeated loads; no counting while high.
REQ-019 SHALL keep all outputs glitch-free registers; no combinational input-to-output path.

Reset
REQ-020 SHALL, while rst is low, force hour=0, min=0, sec=0, day=1, month=1, year=0, prescaler=0, tick=0, independent of clk.
REQ-021 SHALL, while rst is low, force alarm_irq=0 and stored alarm time to 00:00.
REQ-022 SHALL resume counting on the first rising clk edge after rst deasserts; first tick after CLK_FREQ edges.
REQ-023 SHALL abandon any in-progress load or alarm on reset with no residual state.

Configuration
REQ-024 SHALL compile the alarm feature only when macro RTC_ALARM_EN is defined.
REQ-025 With RTC_ALARM_EN: alarm_set high loads alarm_hour_in/alarm_min_in (same sanitising as REQ-017; hour >23 or min >59 -> 0).
REQ-026 With RTC_ALARM_EN: on the tick edge producing hour:min:00 equal to stored alarm, alarm_irq SHALL set next cycle and stay high until alarm_ack.
REQ-027 With RTC_ALARM_EN: alarm_ack and a new match in the same cycle SHALL leave alarm_irq high; a synced load onto the alarm time SHALL NOT set it.
REQ-028 Without RTC_ALARM_EN: alarm ports, stored alarm registers and compare logic SHALL be absent; all other behaviour identical.

Verification (CLK_FREQ=10, YEAR_W=7)
REQ-029 Reset then run 30 cycles -> tick every 10 cycles, sec 0->1->2->3, all others at reset values.
REQ-030 synced with 23:59:58, day 31, month 12, year 5; 20 cycles -> 00:00:00, day 1, month 1, year 6.
REQ-031 Load 23:59:59 28/2 year 4 -> next tick 29/2; load same with year 100 -> next tick 1/3.
REQ-032 synced held high on the prescaler-wrap cycle -> loaded values unchanged, no tick, prescaler restarts at 0.
REQ-033 Load day_in 31, month_in 4, sec_in 61, hour_in 25 -> day 1, sec 0, hour 0, month 4.
REQ-034 RTC_ALARM_EN: alarm 07:30, load 07:29:59 -> alarm_irq high after next tick, held until alarm_ack, then low; rst low mid-alarm -> alarm_irq 0 immediately.
